// File: rtl/up_dn_counter_pkg.sv
// Shared types and helpers for the multi-channel up/down counter bank.
package up_dn_counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

  // MAX_VALUE+1 computed in 64 bits so a full-range 32-bit bound cannot overflow.
  function automatic longint unsigned bound_plus_one(input longint unsigned max_value);
    return max_value + 64'd1;
  endfunction

endpackage

// File: rtl/up_dn_counter_ch.sv
// One counter channel: count register, terminal-count flags, sticky ovf/unf.
module up_dn_counter_ch
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned           WIDTH       = 32,
  parameter int unsigned           STEP_W      = 4,
  parameter logic [WIDTH-1:0]      MAX_VALUE   = '1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter cnt_mode_e             MODE        = CNT_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              incr,
  input  logic              decr,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap_pulse,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned   W1    = WIDTH + 1;
  localparam int unsigned   SW    = (STEP_W > W1) ? STEP_W : W1;
  localparam logic [W1-1:0] MAX_W = {1'b0, MAX_VALUE};
  localparam logic [W1-1:0] MOD   = W1'(bound_plus_one(64'(MAX_VALUE)));

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [SW-1:0] s_raw;
  logic [W1-1:0] s_eff;
  logic [W1-1:0] cur;
  logic [W1-1:0] sum;
  logic          cross_up;
  logic          cross_dn;

  always_comb begin
    s_raw = (step == '0) ? SW'(1) : SW'(step);
    // Oversized steps: modulo reduce when wrapping, clamp to a full lap when saturating.
    if (s_raw > SW'(MOD)) begin
      s_eff = (MODE == CNT_WRAP) ? W1'(s_raw % SW'(MOD)) : MOD;
    end else begin
      s_eff = W1'(s_raw);
    end

    cur      = {1'b0, count_q};
    sum      = cur + s_eff;
    count_d  = count_q;
    cross_up = 1'b0;
    cross_dn = 1'b0;

    if (load) begin
      count_d = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    end else if (incr ^ decr) begin
      if (incr) begin
        if (sum > MAX_W) begin
          cross_up = 1'b1;
          count_d  = (MODE == CNT_WRAP) ? WIDTH'(sum - MOD) : MAX_VALUE;
        end else begin
          count_d = WIDTH'(sum);
        end
      end else begin
        if (cur < s_eff) begin
          cross_dn = 1'b1;
          count_d  = (MODE == CNT_WRAP) ? WIDTH'(cur + MOD - s_eff) : '0;
        end else begin
          count_d = WIDTH'(cur - s_eff);
        end
      end
    end

    at_max_d     = (count_d == MAX_VALUE);
    at_min_d     = (count_d == '0);
    wrap_pulse_d = cross_up | cross_dn;
    ovf_d        = (ovf_q & ~clr_flags) | cross_up;
    unf_d        = (unf_q & ~clr_flags) | cross_dn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= RESET_VALUE;
      at_max_q     <= (RESET_VALUE == MAX_VALUE);
      at_min_q     <= (RESET_VALUE == '0);
      wrap_pulse_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      at_max_q     <= at_max_d;
      at_min_q     <= at_min_d;
      wrap_pulse_q <= wrap_pulse_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign count      = count_q;
  assign at_max     = at_max_q;
  assign at_min     = at_min_q;
  assign wrap_pulse = wrap_pulse_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;

endmodule

// File: rtl/up_dn_counter_mc.sv
// Bank of NUM_CH independent up/down counters sharing only the step input.
module up_dn_counter_mc
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STEP_W      = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE   = '1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      SATURATE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       incr,
  input  logic [NUM_CH-1:0]       decr,
  input  logic [STEP_W-1:0]       step,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_value,
  input  logic [NUM_CH-1:0]       clr_flags,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       at_max,
  output logic [NUM_CH-1:0]       at_min,
  output logic [NUM_CH-1:0]       wrap_pulse,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       unf
);

  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SATURATE : CNT_WRAP;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    up_dn_counter_ch #(
      .WIDTH       (WIDTH),
      .STEP_W      (STEP_W),
      .MAX_VALUE   (MAX_VALUE),
      .RESET_VALUE (RESET_VALUE),
      .MODE        (MODE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .incr       (incr[i]),
      .decr       (decr[i]),
      .step       (step),
      .load       (load[i]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .clr_flags  (clr_flags[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i]),
      .wrap_pulse (wrap_pulse[i]),
      .ovf        (ovf[i]),
      .unf        (unf[i])
    );
  end

endmodule

// File: tb/tb_up_dn_counter_mc.sv
// Directed bench: 8-bit wrap and saturate banks (MAX=200) plus a full-range 32-bit bank.
module tb_up_dn_counter_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  incr, decr, load, clr;
  logic [3:0]  step;
  logic [31:0] lv8;

  logic [31:0] cnt_w, cnt_s;
  logic [3:0]  amax_w, amin_w, wp_w, ovf_w, unf_w;
  logic [3:0]  amax_s, amin_s, wp_s, ovf_s, unf_s;

  logic [3:0]   incr32, decr32, load32;
  logic [127:0] lv32, cnt_32;
  logic [3:0]   amax_32, amin_32, wp_32, ovf_32, unf_32;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  up_dn_counter_mc #(.NUM_CH(4), .WIDTH(8), .STEP_W(4), .MAX_VALUE(8'd200),
                     .RESET_VALUE(8'd0), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .incr(incr), .decr(decr), .step(step), .load(load),
    .load_value(lv8), .clr_flags(clr), .count(cnt_w), .at_max(amax_w), .at_min(amin_w),
    .wrap_pulse(wp_w), .ovf(ovf_w), .unf(unf_w));

  up_dn_counter_mc #(.NUM_CH(4), .WIDTH(8), .STEP_W(4), .MAX_VALUE(8'd200),
                     .RESET_VALUE(8'd0), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .incr(incr), .decr(decr), .step(step), .load(load),
    .load_value(lv8), .clr_flags(clr), .count(cnt_s), .at_max(amax_s), .at_min(amin_s),
    .wrap_pulse(wp_s), .ovf(ovf_s), .unf(unf_s));

  up_dn_counter_mc #(.NUM_CH(4), .WIDTH(32), .STEP_W(4)) dut_32 (
    .clk(clk), .reset(reset), .incr(incr32), .decr(decr32), .step(step), .load(load32),
    .load_value(lv32), .clr_flags(4'b0000), .count(cnt_32), .at_max(amax_32),
    .at_min(amin_32), .wrap_pulse(wp_32), .ovf(ovf_32), .unf(unf_32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch8(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  function automatic logic [31:0] ch32(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic idle();
    incr = '0; decr = '0; load = '0; clr = '0;
    incr32 = '0; decr32 = '0; load32 = '0;
  endtask

  initial begin
    reset = 1'b1; step = 4'd1; lv8 = '0; lv32 = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cnt_w", cnt_w, 32'd0);
    chk("rst_amin_w", amin_w, 4'hF);
    chk("rst_amax_w", amax_w, 4'h0);
    chk("rst_flags_w", {wp_w, ovf_w, unf_w}, 12'h000);
    chk("rst_cnt_32", cnt_32, 128'd0);

    // ch0=198, ch1=2, ch2=250 (clamped, incr ignored under load), ch3=7
    load = 4'hF; lv8 = {8'd7, 8'd250, 8'd2, 8'd198}; incr = 4'b0100;
    tick();
    idle();
    chk("load_cnt_w", cnt_w, {8'd7, 8'd200, 8'd2, 8'd198});
    chk("load_cnt_s", cnt_s, {8'd7, 8'd200, 8'd2, 8'd198});
    chk("load_amax_w", amax_w, 4'b0100);
    chk("load_noflags", {wp_w, ovf_w, unf_w, wp_s, ovf_s, unf_s}, 24'h0);

    // up-count 198+3 crosses 200: wrap lands on 0, saturate clamps at 200
    incr = 4'b0001; step = 4'd3;
    tick();
    chk("up_wrap_cnt0", ch8(cnt_w, 0), 8'd0);
    chk("up_wrap_wp", wp_w, 4'b0001);
    chk("up_wrap_ovf", ovf_w, 4'b0001);
    chk("up_wrap_amax0", amax_w[0], 1'b0);
    chk("up_sat_cnt0", ch8(cnt_s, 0), 8'd200);
    chk("up_sat_amax0", amax_s[0], 1'b1);
    chk("up_sat_ovf", ovf_s, 4'b0001);

    tick();
    chk("up2_wrap_cnt0", ch8(cnt_w, 0), 8'd3);
    chk("up2_wrap_wp", wp_w, 4'b0000);
    chk("up2_wrap_ovf", ovf_w, 4'b0001);
    chk("up2_sat_cnt0", ch8(cnt_s, 0), 8'd200);
    chk("up2_sat_wp", wp_s, 4'b0001);

    // down-count 2-5 underflows: wrap to 2+201-5=198, saturate to 0
    idle(); decr = 4'b0010; step = 4'd5;
    tick();
    chk("dn_wrap_cnt1", ch8(cnt_w, 1), 8'd198);
    chk("dn_wrap_unf", unf_w, 4'b0010);
    chk("dn_wrap_wp", wp_w, 4'b0010);
    chk("dn_sat_cnt1", ch8(cnt_s, 1), 8'd0);
    chk("dn_sat_amin1", amin_s[1], 1'b1);

    idle(); clr = 4'b0011;
    tick();
    chk("clr_unf_w", unf_w, 4'b0000);
    chk("clr_ovf_w", ovf_w, 4'b0000);
    chk("clr_wp_w", wp_w, 4'b0000);

    // incr and decr together hold
    idle(); incr = 4'b0100; decr = 4'b0100;
    tick();
    chk("hold_cnt2", ch8(cnt_w, 2), 8'd200);
    chk("hold_wp", wp_w, 4'b0000);

    idle(); incr = 4'b1000; step = 4'd0;
    tick();
    chk("step0_cnt3", ch8(cnt_w, 3), 8'd8);

    idle(); load = 4'b1000; lv8 = {8'd200, 24'd0};
    tick();
    chk("ld200_amax3", amax_w[3], 1'b1);

    // set beats same-cycle clear
    idle(); incr = 4'b1000; clr = 4'b1000; step = 4'd0;
    tick();
    chk("setwin_cnt3", ch8(cnt_w, 3), 8'd0);
    chk("setwin_ovf3", ovf_w[3], 1'b1);
    chk("setwin_wp3", wp_w[3], 1'b1);

    // reset overrides counting and load on the same edge
    idle(); incr = 4'hF; load = 4'b0001; lv8 = 32'h0505_0505; reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    chk("midrst_cnt_w", cnt_w, 32'd0);
    chk("midrst_cnt_s", cnt_s, 32'd0);
    chk("midrst_flags_w", {wp_w, ovf_w, unf_w}, 12'h000);
    chk("midrst_amin_w", amin_w, 4'hF);

    // full-range 32-bit: wrap past 0xFFFFFFFF and below 0
    load32 = 4'b0001; lv32 = {96'd0, 32'hFFFF_FFFF}; step = 4'd1;
    tick();
    idle();
    chk("w32_ld_amax", amax_32, 4'b0001);
    incr32 = 4'b0001; decr32 = 4'b0010;
    tick();
    idle();
    chk("w32_up_cnt0", ch32(cnt_32, 0), 32'h0000_0000);
    chk("w32_dn_cnt1", ch32(cnt_32, 1), 32'hFFFF_FFFF);
    chk("w32_wp", wp_32, 4'b0011);
    chk("w32_ovf_unf", {ovf_32, unf_32}, 8'b0001_0010);
    chk("w32_amin_amax", {amin_32, amax_32}, 8'b1101_0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
